// File: rtl/dmem_pkg.sv
// Shared DMem definitions: default address/data widths, the derived
// word-count width and the copy engine state encoding.
package dmem_pkg;

    localparam int DMEM_ADDRESS_WIDTH = 16;
    localparam int DMEM_DATA_WIDTH    = 32;

    // One extra bit so a full-memory copy (2^ADDRESS_WIDTH words) fits.
    localparam int DMEM_LEN_WIDTH     = DMEM_ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/dmem_copy_engine_if.sv
// DMem single-port bus: Address/WriteData/MemWrite out, MemData back.
// master = engine (drives the port), slave = memory side.
interface dmem_copy_engine_if
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DMEM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DMEM_DATA_WIDTH
);

    logic [ADDRESS_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0]    WriteData;
    logic                     MemWrite;
    logic [DATA_WIDTH-1:0]    MemData;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        input  MemData
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        output MemData
    );

endinterface

// File: rtl/dmem_copy_engine.sv
// DMem block-copy engine: one read cycle + one write cycle per word,
// ascending order, pointers wrap modulo 2^ADDRESS_WIDTH.
// Ports: Clk, Rst_n (async, active-low); Start/SrcAddr/DstAddr/Length
// request; Busy, Done status; mem = DMem bus (master modport);
// Checksum only when DMEM_COPY_CHECKSUM_EN is defined.
module dmem_copy_engine
    import dmem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DMEM_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DMEM_DATA_WIDTH,
    parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Start,
    input  logic [ADDRESS_WIDTH-1:0] SrcAddr,
    input  logic [ADDRESS_WIDTH-1:0] DstAddr,
    input  logic [LEN_WIDTH-1:0]     Length,
    output logic                     Busy,
    output logic                     Done,
`ifdef DMEM_COPY_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]    Checksum,
`endif
    dmem_copy_engine_if.master       mem
);

    copy_state_t              state;
    logic [ADDRESS_WIDTH-1:0] src;
    logic [ADDRESS_WIDTH-1:0] dst;
    logic [LEN_WIDTH-1:0]     cnt;

`ifdef DMEM_COPY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    sum;

    assign Checksum = sum;
`endif

    // WriteData doubles as the data register: the word captured at the
    // end of READ is exactly what is presented during WRITE.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            src           <= '0;
            dst           <= '0;
            cnt           <= '0;
            Busy          <= 1'b0;
            Done          <= 1'b0;
            mem.Address   <= '0;
            mem.WriteData <= '0;
            mem.MemWrite  <= 1'b0;
`ifdef DMEM_COPY_CHECKSUM_EN
            sum           <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        src <= SrcAddr;
                        dst <= DstAddr;
                        cnt <= Length;
`ifdef DMEM_COPY_CHECKSUM_EN
                        sum <= '0;
`endif
                        if (Length != '0) begin
                            state       <= READ;
                            Busy        <= 1'b1;
                            mem.Address <= SrcAddr;
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state         <= WRITE;
                    mem.WriteData <= mem.MemData;
                    mem.Address   <= dst;
                    mem.MemWrite  <= 1'b1;
`ifdef DMEM_COPY_CHECKSUM_EN
                    sum           <= sum + mem.MemData;
`endif
                end
                WRITE: begin
                    src           <= src + ADDRESS_WIDTH'(1);
                    dst           <= dst + ADDRESS_WIDTH'(1);
                    cnt           <= cnt - LEN_WIDTH'(1);
                    mem.MemWrite  <= 1'b0;
                    mem.WriteData <= '0;
                    if (cnt == LEN_WIDTH'(1)) begin
                        state       <= DONE;
                        Busy        <= 1'b0;
                        Done        <= 1'b1;
                        mem.Address <= '0;
                    end else begin
                        state       <= READ;
                        mem.Address <= src + ADDRESS_WIDTH'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Randomized + directed bench for dmem_copy_engine with a DMem model
// (comb read, negedge write) and a word-level copy reference model.
module tb_dmem_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Start;
    logic [15:0] SrcAddr;
    logic [15:0] DstAddr;
    logic [16:0] Length;
    logic        Busy;
    logic        Done;
`ifdef DMEM_COPY_CHECKSUM_EN
    logic [31:0] Checksum;
`endif

    dmem_copy_engine_if bus ();

    dmem_copy_engine dut (
        .Clk     (clk),
        .Rst_n   (rst_n),
        .Start   (Start),
        .SrcAddr (SrcAddr),
        .DstAddr (DstAddr),
        .Length  (Length),
        .Busy    (Busy),
        .Done    (Done),
`ifdef DMEM_COPY_CHECKSUM_EN
        .Checksum(Checksum),
`endif
        .mem     (bus.master)
    );

    always #5 clk = ~clk;

    logic [31:0] mem     [65536];
    logic [31:0] ref_mem [65536];
    logic [31:0] init_seed;
    logic        init_req;
    logic        hw_we;
    logic [15:0] hw_addr;
    logic [31:0] hw_data;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] fill_val(input int i);
        return (32'(i) * 32'h9E3779B1) ^ init_seed;
    endfunction

    assign bus.MemData = mem[bus.Address];

    // DMem model: single writer process for the memory array.
    always @(negedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 65536; i++) mem[i] = fill_val(i);
        end else if (bus.MemWrite) begin
            mem[bus.Address] = bus.WriteData;
        end else if (hw_we) begin
            mem[hw_addr] = hw_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [15:0] a, input logic [31:0] d);
        @(posedge clk);
        hw_addr = a;
        hw_data = d;
        hw_we   = 1'b1;
        ref_mem[a] = d;
        @(negedge clk);
        #1 hw_we = 1'b0;
    endtask

    task automatic run_copy(input logic [15:0] s, input logic [15:0] d,
                            input int n);
        logic [31:0] wd [$];
        logic [31:0] sum;
        logic [31:0] v;
        logic [63:0] exp_v;
        logic [63:0] obs_v;
        logic        mw_e;
        logic [15:0] a_e;
        logic [31:0] wd_e;
        logic [15:0] a;
        int          k;
        sum = 32'h0;
        for (int i = 0; i < n; i++) begin
            v = ref_mem[s + 16'(i)];
            wd.push_back(v);
            ref_mem[d + 16'(i)] = v;
            sum += v;
        end
        @(negedge clk);
        Start   = 1'b1;
        SrcAddr = s;
        DstAddr = d;
        Length  = 17'(n);
        @(posedge clk);
        #1 Start = 1'b0;
        for (int c = 1; c <= 2 * n + 2; c++) begin
            @(negedge clk);
            if (c <= 2 * n) begin
                k    = (c - 1) / 2;
                mw_e = (c % 2 == 0);
                a_e  = mw_e ? d + 16'(k) : s + 16'(k);
                wd_e = mw_e ? wd[k] : 32'h0;
                exp_v = {13'b0, 1'b1, 1'b0, mw_e, a_e, wd_e};
            end else begin
                exp_v = {13'b0, 1'b0, 1'(c == 2 * n + 1), 1'b0, 16'h0, 32'h0};
            end
            obs_v = {13'b0, Busy, Done, bus.MemWrite, bus.Address,
                     bus.MemWrite ? bus.WriteData : 32'h0};
            check($sformatf("cyc%0d", c), obs_v, exp_v);
`ifdef DMEM_COPY_CHECKSUM_EN
            if (c == 2 * n + 1) check("csum", 64'(Checksum), 64'(sum));
`endif
        end
        for (int i = -1; i <= n; i++) begin
            a = d + 16'(i);
            check($sformatf("mem[%h]", a), 64'(mem[a]), 64'(ref_mem[a]));
        end
    endtask

    task automatic abort_copy(input logic [15:0] s, input logic [15:0] d);
        logic [15:0] a;
        // Only words 0 and 1 complete before the reset hits word 2's READ.
        ref_mem[d]           = ref_mem[s];
        ref_mem[d + 16'd1]   = ref_mem[s + 16'd1];
        @(negedge clk);
        Start   = 1'b1;
        SrcAddr = s;
        DstAddr = d;
        Length  = 17'd4;
        @(posedge clk);
        #1 Start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("rst_out", {13'b0, Busy, Done, bus.MemWrite, bus.Address,
                             bus.WriteData}, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_idle", {62'b0, Busy, Done}, 64'h0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_done", {63'b0, Done}, 64'h0);
        for (int i = -1; i <= 4; i++) begin
            a = d + 16'(i);
            check($sformatf("abort_mem[%h]", a), 64'(mem[a]), 64'(ref_mem[a]));
        end
    endtask

    initial begin
        logic [15:0] rs;
        logic [15:0] rd;
        int          rn;
        rst_n     = 1'b0;
        Start     = 1'b0;
        SrcAddr   = '0;
        DstAddr   = '0;
        Length    = '0;
        hw_we     = 1'b0;
        hw_addr   = '0;
        hw_data   = '0;
        init_seed = $urandom;
        for (int i = 0; i < 65536; i++) ref_mem[i] = fill_val(i);
        init_req  = 1'b1;
        repeat (2) @(negedge clk);
        init_req  = 1'b0;
        @(posedge clk);
        #1 check("reset", {13'b0, Busy, Done, bus.MemWrite, bus.Address,
                           bus.WriteData}, 64'h0);
`ifdef DMEM_COPY_CHECKSUM_EN
        check("reset_csum", 64'(Checksum), 64'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) host_wr(16'h10 + 16'(i), 32'hA0 + 32'(i));
        run_copy(16'h0010, 16'h0040, 4);
        check("basic_lit", 64'(mem[16'h43]), 64'h0000_00A3);

        run_copy(16'h0055, 16'h0066, 0);
        run_copy(16'hFFFE, 16'h0100, 3);

        host_wr(16'h20, 32'h11);
        host_wr(16'h21, 32'h22);
        run_copy(16'h0020, 16'h0021, 2);
        check("ovl_lit", 64'(mem[16'h22]), 64'h11);

        host_wr(16'h30, 32'hFFFF_FFFF);
        host_wr(16'h31, 32'h0000_0002);
        run_copy(16'h0030, 16'h0050, 2);

        abort_copy(16'h0200, 16'h0300);
        run_copy(16'h0200, 16'h0300, 4);

        for (int t = 0; t < 20; t++) begin
            rs = 16'($urandom);
            rd = 16'($urandom);
            rn = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
            run_copy(rs, rd, rn);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
# dmem_copy_engine

Block-copy initiator that drives the data memory's single port (Address, WriteData, MemWrite, MemData) to move a run of words from a source address to a destination address without CPU involvement. It sits between the datapath's memory-port mux and DMem and owns the port while Busy is high. It issues one read cycle and one write cycle per word, matching DMem's combinational read and negedge write.

## Interface
- ADDRESS_WIDTH, 16, DMem address width
- DATA_WIDTH, 32, DMem word width
- LEN_WIDTH, ADDRESS_WIDTH+1, word-count width, so a full-memory copy is expressible
- Clk  input  1  clock; all state updates on posedge
- Rst_n  input  1  reset, asynchronous, active-low
- Start  input  1  request a copy; sampled on posedge while idle
- SrcAddr  input  ADDRESS_WIDTH  first source word address; sampled with Start
- DstAddr  input  ADDRESS_WIDTH  first destination word address; sampled with Start
- Length  input  LEN_WIDTH  number of words; sampled with Start
- Busy  output  1  engine owns the DMem port
- Done  output  1  one-cycle completion pulse
- Address  output  ADDRESS_WIDTH  to DMem Address
- WriteData  output  DATA_WIDTH  to DMem WriteData
- MemWrite  output  1  to DMem MemWrite
- MemData  input  DATA_WIDTH  from DMem MemData, combinational read
- Checksum  output  DATA_WIDTH  present only with DMEM_COPY_CHECKSUM_EN

## Operation
- The FSM has four states: IDLE, READ, WRITE, DONE.
- **IDLE:** Start=1 with Length≠0 latches SrcAddr, DstAddr and Length, then goes to READ. Start=1 with Length=0 goes to DONE and issues no memory traffic. Start=0 stays in IDLE.
- **READ:** Address=src pointer and MemWrite=0. MemData is captured into the data register at the closing posedge. The state then goes to WRITE.
- **WRITE:** Address=dst pointer, WriteData=data register, MemWrite=1. DMem commits the word at the mid-cycle negedge. At the closing posedge both pointers increment and the remaining count decrements. If the count reaches 0 the state goes to DONE, otherwise back to READ.
- **DONE:** Done=1 for exactly one cycle, then the state goes to IDLE.
- Start is ignored in every state except IDLE. There is no abort input.
- Pointers wrap modulo 2^ADDRESS_WIDTH (0xFFFF+1 → 0x0000).
- Copy order is strictly ascending. Overlapping regions with Dst>Src therefore replicate the leading words; this is the defined behaviour.
- Address, WriteData and MemWrite are registered outputs that change only on posedge, so they are stable at the DMem write negedge.
- In IDLE and DONE: Address=0, WriteData=0, MemWrite=0.

## Timing
- Reset values: Busy=0, Done=0, Address=0, WriteData=0, MemWrite=0, Checksum=0, state=IDLE.
- Busy=1 in READ and WRITE only.
- Let posedge 0 be the posedge where Start is accepted. Word i is read in cycle 1+2i and written in cycle 2+2i. Done is high in cycle 2N+1, and the engine is back in IDLE in cycle 2N+2.
- With Length=0, Done is high in cycle 1.
- Throughput is 2 cycles per word.
- If Rst_n falls mid-copy, all outputs clear immediately. If Rst_n falls before the negedge of a WRITE cycle, that word is not written. Words already written stay in memory, and no Done is issued.
- Start held high continuously starts a new copy in the cycle after DONE.

## Configuration
- `DMEM_COPY_CHECKSUM_EN` defined: the Checksum port exists. It is cleared when Start is accepted and accumulates a DATA_WIDTH modulo-2^DATA_WIDTH sum of every word captured in READ. It is valid, and holds its value, from the Done cycle until the next accepted Start.
- Undefined: neither the Checksum port nor the accumulator exists. All other behaviour is identical.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (IDLE, READ, WRITE, DONE);
  - default ADDRESS_WIDTH and DATA_WIDTH constants, shared with DMem;
  - LEN_WIDTH derivation.
- No sub-module: a single module containing the FSM, two pointers, the count and the data register.

## Test plan
- Preload mem[0x10..0x13] = 0xA0..0xA3; Start with Src=0x10, Dst=0x40, Len=4 → mem[0x40..0x43] = 0xA0..0xA3; Done high exactly at cycle 9; MemWrite high in cycles 2, 4, 6, 8 only.
- Start with Len=0 → Done in cycle 1; MemWrite never asserted; Busy stays 0.
- Src=0xFFFE, Dst=0x0100, Len=3 → reads at 0xFFFE, 0xFFFF, 0x0000 (wrap); writes at 0x0100..0x0102.
- Overlap: mem[0x20]=0x11, mem[0x21]=0x22; Src=0x20, Dst=0x21, Len=2 → mem[0x21]=0x11 and mem[0x22]=0x11.
- Assert Rst_n=0 during the READ cycle of word 2 in a 4-word copy → outputs zero immediately; only words 0 and 1 are written; no Done; a new Start after release copies correctly.
- With DMEM_COPY_CHECKSUM_EN, copy words 0xFFFFFFFF and 0x00000002 → Checksum = 0x00000001 at Done.
